// File: rtl/clock_monitor_pkg.sv
// rtl/clock_monitor_pkg.sv - shared constants and FSM state type for clock_edge_monitor
package clock_monitor_pkg;

   localparam int CLK_HZ          = 50_000_000;
   localparam int DEFAULT_TIMEOUT = 10_000_000;

   typedef enum logic [1:0] {
      ST_ACQUIRE = 2'd0,
      ST_MEASURE = 2'd1,
      ST_LOST    = 2'd2
   } state_t;

endpackage

// File: rtl/sync_edge_detect.sv
// rtl/sync_edge_detect.sv - multi-flop synchroniser with a registered rising-edge pulse
module sync_edge_detect #(
   parameter int SYNC_STAGES = 2
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_sig,
   output logic o_rise
);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_prev;
   logic                   r_rise;
   logic                   w_rise;

   assign w_rise = r_sync[SYNC_STAGES-1] & ~r_prev;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_sync <= '0;
         r_prev <= 1'b0;
         r_rise <= 1'b0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_sig};
         r_prev <= r_sync[SYNC_STAGES-1];
         r_rise <= w_rise;
      end
   end

   assign o_rise = r_rise;

endmodule

// File: rtl/clock_edge_monitor.sv
// rtl/clock_edge_monitor.sv - slow-clock tick generator, period meter and loss detector
// Optional period deviation checker enabled by PERIOD_CHECK_EN.
module clock_edge_monitor
   import clock_monitor_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int CNT_W       = 24,
   parameter int TIMEOUT     = DEFAULT_TIMEOUT,
   parameter int EDGE_W      = 16,
   parameter int EXPECTED    = 5_000_000,
   parameter int TOL         = 1000
) (
   input  logic              clk_in,
   input  logic              rst,
   input  logic              slow_clk,
   output logic              tick,
   output logic [CNT_W-1:0]  period,
   output logic              period_stb,
   output logic              period_valid,
   output logic              clk_lost,
   output logic [EDGE_W-1:0] edge_count
`ifdef PERIOD_CHECK_EN
   ,
   output logic              period_err
`endif
);

   localparam logic [CNT_W-1:0] LP_TMO_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] LP_CNT_MAX  = '1;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [CNT_W-1:0]  r_cnt;
   logic [CNT_W-1:0]  r_period;
   logic [EDGE_W-1:0] r_edges;
   logic              r_tick;
   logic              r_stb;
   logic              r_valid;
   logic              r_lost;
   logic              w_rise;
   logic              w_tick_nxt;
   logic              w_stb_nxt;
   logic              w_valid_nxt;
   logic              w_lost_nxt;
   logic [CNT_W-1:0]  w_period_new;

   sync_edge_detect #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync (
      .i_clk  (clk_in),
      .i_rst  (rst),
      .i_sig  (slow_clk),
      .o_rise (w_rise)
   );

   // cnt is cleared on each rise, so cnt+1 is the edge-to-edge distance
   assign w_period_new = r_cnt + 1'b1;

   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         r_state <= ST_ACQUIRE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_tick_nxt  = 1'b0;
      w_stb_nxt   = 1'b0;
      w_valid_nxt = r_valid;
      w_lost_nxt  = r_lost;
      case (r_state)
         ST_ACQUIRE: begin
            if (w_rise) begin
               w_state_nxt = ST_MEASURE;
               w_tick_nxt  = 1'b1;
            end
         end
         ST_MEASURE: begin
            // an edge landing on the timeout cycle still counts as a valid period
            if (w_rise) begin
               w_tick_nxt  = 1'b1;
               w_stb_nxt   = 1'b1;
               w_valid_nxt = 1'b1;
            end else if (r_cnt == LP_TMO_LAST) begin
               w_state_nxt = ST_LOST;
               w_lost_nxt  = 1'b1;
               w_valid_nxt = 1'b0;
            end
         end
         ST_LOST: begin
            if (w_rise) begin
               w_state_nxt = ST_MEASURE;
               w_tick_nxt  = 1'b1;
               w_lost_nxt  = 1'b0;
            end
         end
         default: begin
            w_state_nxt = ST_ACQUIRE;
         end
      endcase
   end

   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         r_cnt    <= '0;
         r_period <= '0;
         r_edges  <= '0;
         r_tick   <= 1'b0;
         r_stb    <= 1'b0;
         r_valid  <= 1'b0;
         r_lost   <= 1'b0;
      end else begin
         r_tick  <= w_tick_nxt;
         r_stb   <= w_stb_nxt;
         r_valid <= w_valid_nxt;
         r_lost  <= w_lost_nxt;
         if (w_stb_nxt) begin
            r_period <= w_period_new;
         end
         if (w_tick_nxt) begin
            r_edges <= r_edges + 1'b1;
         end
         if (w_rise) begin
            r_cnt <= '0;
         end else if (r_cnt != LP_CNT_MAX) begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   assign tick         = r_tick;
   assign period       = r_period;
   assign period_stb   = r_stb;
   assign period_valid = r_valid;
   assign clk_lost     = r_lost;
   assign edge_count   = r_edges;

`ifdef PERIOD_CHECK_EN
   logic signed [CNT_W:0] w_diff;
   logic signed [CNT_W:0] w_abs;
   logic                  w_err_nxt;
   logic                  r_err;

   assign w_diff    = $signed({1'b0, w_period_new}) - $signed((CNT_W+1)'(EXPECTED));
   assign w_abs     = w_diff[CNT_W] ? -w_diff : w_diff;
   assign w_err_nxt = w_stb_nxt && (w_abs > $signed((CNT_W+1)'(TOL)));

   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         r_err <= 1'b0;
      end else begin
         r_err <= w_err_nxt;
      end
   end

   assign period_err = r_err;
`endif

endmodule

// File: tb/tb_clock_edge_monitor.sv
// tb/tb_clock_edge_monitor.sv - scoreboard bench for clock_edge_monitor with a cycle-level reference model
module tb_clock_edge_monitor;

   localparam int SYNC_STAGES = 2;
   localparam int CNT_W       = 8;
   localparam int TIMEOUT     = 100;
   localparam int EDGE_W      = 4;
   localparam int EXPECTED    = 10;
   localparam int TOL         = 1;
   localparam int LAT         = SYNC_STAGES + 1;

   logic              clk_in = 1'b0;
   logic              rst = 1'b1;
   logic              slow_clk = 1'b0;
   logic              tick;
   logic [CNT_W-1:0]  period;
   logic              period_stb;
   logic              period_valid;
   logic              clk_lost;
   logic [EDGE_W-1:0] edge_count;
`ifdef PERIOD_CHECK_EN
   logic              period_err;
`endif

   clock_edge_monitor #(
      .SYNC_STAGES (SYNC_STAGES),
      .CNT_W       (CNT_W),
      .TIMEOUT     (TIMEOUT),
      .EDGE_W      (EDGE_W),
      .EXPECTED    (EXPECTED),
      .TOL         (TOL)
   ) dut (
      .clk_in       (clk_in),
      .rst          (rst),
      .slow_clk     (slow_clk),
      .tick         (tick),
      .period       (period),
      .period_stb   (period_stb),
      .period_valid (period_valid),
      .clk_lost     (clk_lost),
      .edge_count   (edge_count)
`ifdef PERIOD_CHECK_EN
      ,
      .period_err   (period_err)
`endif
   );

   always #5 clk_in = ~clk_in;

   typedef struct {
      int cyc;
      bit stb;
      int per;
      bit valid;
      int edges;
      bit err;
   } ev_t;

   ev_t   sb_q[$];
   ev_t   lost_q[$];
   int    rise_q[$];
   int    total = 0;
   int    bad = 0;
   int    cyc = 0;

   bit    m_prev, m_meas, m_valid;
   int    m_last, m_per, m_edges;
   ev_t   m_ev, c_ev;
   bit    p_tick, p_lost;
   int    h, l;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s at cycle %0d: got=%0d want=%0d", name, cyc, act, exp);
      end
   endtask

   task automatic phase(input logic lvl, input int n);
      slow_clk = lvl;
      repeat (n) begin
         @(posedge clk_in);
         #2;
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_tick"}, int'(tick), 0);
      chk({tag, "_period"}, int'(period), 0);
      chk({tag, "_stb"}, int'(period_stb), 0);
      chk({tag, "_valid"}, int'(period_valid), 0);
      chk({tag, "_lost"}, int'(clk_lost), 0);
      chk({tag, "_edges"}, int'(edge_count), 0);
   endtask

   task automatic mid_reset();
      @(negedge clk_in);
      #1;
      rst = 1'b1;
      #1;
      chk_zero("async_rst");
      for (int i = 0; i < 6; i++) begin
         @(posedge clk_in);
         #2;
         slow_clk = i[0];
      end
      slow_clk = 1'b0;
      @(negedge clk_in);
      #1;
      rst = 1'b0;
      @(posedge clk_in);
      #2;
   endtask

   // Reference model: sampled rising edge at cycle k yields a tick at k+LAT;
   // period is the tick-to-tick distance, loss is TIMEOUT cycles without a tick.
   initial begin : model
      forever begin
         @(posedge clk_in);
         cyc++;
         if (rst) begin
            m_prev = 0; m_meas = 0; m_valid = 0;
            m_per = 0; m_edges = 0; m_last = 0;
            rise_q.delete();
         end else begin
            if (slow_clk && !m_prev) rise_q.push_back(cyc + LAT);
            m_prev = slow_clk;
            if (rise_q.size() > 0 && rise_q[0] == cyc) begin
               void'(rise_q.pop_front());
               m_ev.cyc = cyc;
               m_ev.stb = m_meas;
               if (m_meas) begin
                  m_per = cyc - m_last;
                  m_valid = 1;
               end
               m_ev.err = m_meas && (m_per > EXPECTED + TOL || m_per < EXPECTED - TOL);
               m_edges = (m_edges + 1) % (1 << EDGE_W);
               m_ev.per = m_per;
               m_ev.valid = m_valid;
               m_ev.edges = m_edges;
               m_meas = 1;
               m_last = cyc;
               sb_q.push_back(m_ev);
            end else if (m_meas && (cyc - m_last == TIMEOUT)) begin
               m_meas = 0;
               m_valid = 0;
               m_ev.cyc = cyc;
               m_ev.per = m_per;
               lost_q.push_back(m_ev);
            end
         end
      end
   end

   initial begin : monitor
      forever begin
         @(negedge clk_in);
         if (rst) begin
            p_tick = 0;
            p_lost = 0;
            continue;
         end
         if (tick && p_tick) chk("tick_double", 1, 0);
         if (period_stb && !tick) chk("stb_without_tick", 1, 0);
         if (tick) begin
            if (sb_q.size() == 0) begin
               chk("tick_unexpected", 1, 0);
            end else begin
               c_ev = sb_q.pop_front();
               chk("tick_cycle", cyc, c_ev.cyc);
               chk("period_stb", int'(period_stb), int'(c_ev.stb));
               chk("period", int'(period), c_ev.per);
               chk("period_valid", int'(period_valid), int'(c_ev.valid));
               chk("edge_count", int'(edge_count), c_ev.edges);
               chk("lost_on_tick", int'(clk_lost), 0);
`ifdef PERIOD_CHECK_EN
               chk("period_err", int'(period_err), int'(c_ev.err));
`endif
            end
         end else if (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
            chk("tick_missing", 0, 1);
            void'(sb_q.pop_front());
         end
         if (clk_lost && !p_lost) begin
            if (lost_q.size() == 0) begin
               chk("lost_unexpected", 1, 0);
            end else begin
               c_ev = lost_q.pop_front();
               chk("lost_cycle", cyc, c_ev.cyc);
               chk("lost_valid", int'(period_valid), 0);
               chk("lost_period", int'(period), c_ev.per);
            end
         end else if (lost_q.size() > 0 && lost_q[0].cyc <= cyc) begin
            chk("lost_missing", 0, 1);
            void'(lost_q.pop_front());
         end
         if (!clk_lost && p_lost && !tick) chk("lost_cleared_early", 1, 0);
         p_tick = tick;
         p_lost = clk_lost;
      end
   end

   initial begin : stim
      rst = 1'b1;
      slow_clk = 1'b0;
      repeat (2) @(posedge clk_in);
      #2;
      slow_clk = 1'b1;
      @(posedge clk_in);
      #2;
      slow_clk = 1'b0;
      chk_zero("reset");
      @(negedge clk_in);
      #1;
      rst = 1'b0;
      @(posedge clk_in);
      #2;

      repeat (4) begin phase(1'b1, 5); phase(1'b0, 5); end
      phase(1'b0, 130);
      repeat (3) begin phase(1'b1, 5); phase(1'b0, 5); end

      repeat (2) begin phase(1'b1, 50); phase(1'b0, 50); end
      phase(1'b1, 50); phase(1'b0, 51);
      phase(1'b1, 50); phase(1'b0, 50);

      phase(1'b1, 5); phase(1'b0, 6);
      phase(1'b1, 6); phase(1'b0, 6);
      phase(1'b1, 5); phase(1'b0, 5);

      phase(1'b1, 5); phase(1'b0, 3);
      mid_reset();
      repeat (3) begin phase(1'b1, 5); phase(1'b0, 5); end

      for (int i = 0; i < 150; i++) begin
         h = $urandom_range(1, 8);
         l = $urandom_range(1, 8);
         if ($urandom_range(0, 9) == 0) l = $urandom_range(90, 110);
         phase(1'b1, h);
         phase(1'b0, l);
      end

      phase(1'b0, 120);
      repeat (5) @(posedge clk_in);
      #2;
      chk("sb_drained", sb_q.size(), 0);
      chk("lost_drained", lost_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
